// File: rtl/bsds_rgb2gray_pkg.sv
// ----------------------------------------------------------------------------
// bsds_rgb2gray_pkg
// Shared constants for the pipelined RGB-to-gray converter: conversion mode
// encodings, BT.601 luma weights (expressed in 1/256 units), and the
// reciprocal-of-three constant used by the MEAN mode.
// ----------------------------------------------------------------------------
package bsds_rgb2gray_pkg;

    // Conversion mode encodings carried on mode_in / mode_out
    localparam logic [1:0] MODE_LEGACY = 2'd0;
    localparam logic [1:0] MODE_BT601  = 2'd1;
    localparam logic [1:0] MODE_MEAN   = 2'd2;
    localparam logic [1:0] MODE_MAX    = 2'd3;

    // BT.601 luma weights in 1/256 units; they sum to exactly 256 so a
    // white pixel maps to full scale before rounding.
    localparam int BT601_WR = 77;
    localparam int BT601_WG = 150;
    localparam int BT601_WB = 29;

    // MEAN mode: (R+G+B)/3 approximated as (R+G+B)*171/512
    localparam int MEAN_MUL   = 171;
    localparam int MEAN_SHIFT = 9;

    // Rescale a 1/256 weight to the configured number of fraction bits.
    function automatic int scale_weight(input int w, input int frac_bits);
        return (w << frac_bits) >> 8;
    endfunction

endpackage

// File: rtl/bsds_rgb2gray_mac.sv
// ----------------------------------------------------------------------------
// bsds_rgb2gray_mac
// Combinational weighted-sum stage of the RGB-to-gray pipeline. Produces the
// unrounded, unshifted sum for the LEGACY/BT601/MEAN modes and, in parallel,
// the channel maximum for the MAX mode. The parent registers both results.
//
// Ports
//   r, g, b   in   DATA_WIDTH               colour samples
//   mode      in   2                        conversion mode for this pixel
//   sum       out  DATA_WIDTH+COEF_WIDTH+2  weighted sum (mode dependent)
//   max_val   out  DATA_WIDTH               max(r, g, b)
// ----------------------------------------------------------------------------
module bsds_rgb2gray_mac
    import bsds_rgb2gray_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]            r,
    input  logic [DATA_WIDTH-1:0]            g,
    input  logic [DATA_WIDTH-1:0]            b,
    input  logic [1:0]                       mode,
    output logic [DATA_WIDTH+COEF_WIDTH+1:0] sum,
    output logic [DATA_WIDTH-1:0]            max_val
);

    localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + 2;

    localparam logic [ACC_W-1:0] WR     = ACC_W'(scale_weight(BT601_WR, COEF_WIDTH));
    localparam logic [ACC_W-1:0] WG     = ACC_W'(scale_weight(BT601_WG, COEF_WIDTH));
    localparam logic [ACC_W-1:0] WB     = ACC_W'(scale_weight(BT601_WB, COEF_WIDTH));
    localparam logic [ACC_W-1:0] MEAN_K = ACC_W'(MEAN_MUL);

    logic [ACC_W-1:0] r_ext;
    logic [ACC_W-1:0] g_ext;
    logic [ACC_W-1:0] b_ext;

    assign r_ext = ACC_W'(r);
    assign g_ext = ACC_W'(g);
    assign b_ext = ACC_W'(b);

    always_comb begin
        sum = '0;
        case (mode)
            MODE_LEGACY: sum = r_ext + (g_ext << 1) + b_ext;
            MODE_BT601:  sum = WR * r_ext + WG * g_ext + WB * b_ext;
            MODE_MEAN:   sum = (r_ext + g_ext + b_ext) * MEAN_K;
            default:     sum = '0;   // MAX mode uses max_val instead
        endcase
    end

    always_comb begin
        max_val = r;
        if (g > max_val) max_val = g;
        if (b > max_val) max_val = b;
    end

endmodule

// File: rtl/bsds_rgb2gray_pipe.sv
// ----------------------------------------------------------------------------
// bsds_rgb2gray_pipe
// Three-stage pipelined RGB-to-gray converter with valid/ready handshake,
// frame markers and four run-time conversion modes. One pixel per clock,
// three cycles of latency. The whole pipeline advances on a single enable,
// so a stalled output freezes every stage (no skid buffer).
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   r/g/b_data_in in N  colour samples
//   sof_in     in   1   first pixel of frame (qualified by valid_in)
//   eol_in     in   1   last pixel of line (qualified by valid_in)
//   mode_in    in   2   mode request, latched only on an accepted sof beat
//   valid_in   in   1   input beat valid
//   ready_out  out  1   block accepts a beat this cycle
//   data_out   out  N   gray sample
//   sof_out    out  1   sof aligned with data_out
//   eol_out    out  1   eol aligned with data_out
//   mode_out   out  2   mode used for the current data_out beat
//   valid_out  out  1   output beat valid
//   ready_in   in   1   downstream accepts the beat this cycle
// ----------------------------------------------------------------------------
module bsds_rgb2gray_pipe
    import bsds_rgb2gray_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] r_data_in,
    input  logic [DATA_WIDTH-1:0] g_data_in,
    input  logic [DATA_WIDTH-1:0] b_data_in,
    input  logic                  sof_in,
    input  logic                  eol_in,
    input  logic [1:0]            mode_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  sof_out,
    output logic                  eol_out,
    output logic [1:0]            mode_out,
    output logic                  valid_out,
    input  logic                  ready_in
);

    localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + 2;

    localparam logic [ACC_W:0] SAT_MAX   = (ACC_W+1)'({DATA_WIDTH{1'b1}});
    localparam logic [ACC_W:0] RND_BT601 = (ACC_W+1)'(1) << (COEF_WIDTH - 1);
    localparam logic [ACC_W:0] RND_MEAN  = (ACC_W+1)'(1) << (MEAN_SHIFT - 1);

    // Round-to-nearest and scale the weighted sum back to pixel range.
    // One extra headroom bit absorbs the rounding constant.
    function automatic logic [ACC_W:0] round_shift(input logic [ACC_W-1:0] s,
                                                   input logic [1:0]       m);
        logic [ACC_W:0] v;
        v = {1'b0, s};
        case (m)
            MODE_LEGACY: return v >> 2;
            MODE_BT601:  return (v + RND_BT601) >> COEF_WIDTH;
            MODE_MEAN:   return (v + RND_MEAN) >> MEAN_SHIFT;
            default:     return v;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] saturate(input logic [ACC_W:0] v);
        if (v > SAT_MAX) return {DATA_WIDTH{1'b1}};
        return v[DATA_WIDTH-1:0];
    endfunction

    logic                  en;
    logic                  accept;
    logic [1:0]            active_mode;
    logic [1:0]            mode_eff;

    logic                  vld_p0, vld_p1, vld_p2;
    logic [DATA_WIDTH-1:0] r_p0, g_p0, b_p0;
    logic                  sof_p0, eol_p0;
    logic [1:0]            mode_p0;

    logic [ACC_W-1:0]      sum_c;
    logic [DATA_WIDTH-1:0] max_c;

    logic [ACC_W-1:0]      sum_p1;
    logic [DATA_WIDTH-1:0] max_p1;
    logic                  sof_p1, eol_p1;
    logic [1:0]            mode_p1;

    logic [DATA_WIDTH-1:0] data_p2;
    logic                  sof_p2, eol_p2;
    logic [1:0]            mode_p2;

    // Whole pipeline moves unless a valid beat is parked at the output.
    assign en        = !vld_p2 || ready_in;
    assign ready_out = en;
    assign accept    = valid_in && en;

    // A sof beat takes its own requested mode, not the previously latched one.
    assign mode_eff = (valid_in && sof_in) ? mode_in : active_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_mode <= MODE_LEGACY;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
        end else begin
            if (accept && sof_in) active_mode <= mode_in;
            if (en) begin
                vld_p0 <= valid_in;
                vld_p1 <= vld_p0;
                vld_p2 <= vld_p1;
            end
        end
    end

    // ---- S1: register input pixel, markers and effective mode ----
    always_ff @(posedge clk) begin
        if (en) begin
            r_p0    <= r_data_in;
            g_p0    <= g_data_in;
            b_p0    <= b_data_in;
            sof_p0  <= sof_in;
            eol_p0  <= eol_in;
            mode_p0 <= mode_eff;
        end
    end

    bsds_rgb2gray_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH)
    ) u_mac (
        .r       (r_p0),
        .g       (g_p0),
        .b       (b_p0),
        .mode    (mode_p0),
        .sum     (sum_c),
        .max_val (max_c)
    );

    // ---- S2: register weighted sum and channel maximum ----
    always_ff @(posedge clk) begin
        if (en) begin
            sum_p1  <= sum_c;
            max_p1  <= max_c;
            sof_p1  <= sof_p0;
            eol_p1  <= eol_p0;
            mode_p1 <= mode_p0;
        end
    end

    // ---- S3: round, shift, saturate; output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p2 <= '0;
            sof_p2  <= 1'b0;
            eol_p2  <= 1'b0;
            mode_p2 <= MODE_LEGACY;
        end else if (en) begin
            data_p2 <= (mode_p1 == MODE_MAX) ? max_p1
                                             : saturate(round_shift(sum_p1, mode_p1));
            sof_p2  <= sof_p1;
            eol_p2  <= eol_p1;
            mode_p2 <= mode_p1;
        end
    end

    assign data_out  = data_p2;
    assign sof_out   = sof_p2;
    assign eol_out   = eol_p2;
    assign mode_out  = mode_p2;
    assign valid_out = vld_p2;

endmodule
